// File: rtl/bp_dma_to_axi_master.sv
// Bridges the L2 DMA packet/data interface onto an AXI4 master, one fixed-length INCR burst
// per DMA packet, strictly one transaction in flight.
module bp_dma_to_axi_master #(
  parameter int caddr_width_p    = 32,
  parameter int l2_fill_width_p  = 64,
  parameter int l2_block_width_p = 512,
  parameter int axi_addr_width_p = 32,
  parameter logic [axi_addr_width_p-1:0] axi_base_addr_p = '0
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [caddr_width_p:0]        dma_pkt_i,
  input  logic                          dma_pkt_v_i,
  output logic                          dma_pkt_yumi_o,
  input  logic [l2_fill_width_p-1:0]    dma_data_i,
  input  logic                          dma_data_v_i,
  output logic                          dma_data_yumi_o,
  output logic [l2_fill_width_p-1:0]    dma_data_o,
  output logic                          dma_data_v_o,
  input  logic                          dma_data_ready_and_i,
  output logic [axi_addr_width_p-1:0]   m_axi_awaddr_o,
  output logic                          m_axi_awvalid_o,
  input  logic                          m_axi_awready_i,
  output logic [7:0]                    m_axi_awlen_o,
  output logic [2:0]                    m_axi_awsize_o,
  output logic [1:0]                    m_axi_awburst_o,
  output logic [l2_fill_width_p-1:0]    m_axi_wdata_o,
  output logic [l2_fill_width_p/8-1:0]  m_axi_wstrb_o,
  output logic                          m_axi_wlast_o,
  output logic                          m_axi_wvalid_o,
  input  logic                          m_axi_wready_i,
  input  logic [1:0]                    m_axi_bresp_i,
  input  logic                          m_axi_bvalid_i,
  output logic                          m_axi_bready_o,
  output logic [axi_addr_width_p-1:0]   m_axi_araddr_o,
  output logic                          m_axi_arvalid_o,
  input  logic                          m_axi_arready_i,
  output logic [7:0]                    m_axi_arlen_o,
  output logic [2:0]                    m_axi_arsize_o,
  output logic [1:0]                    m_axi_arburst_o,
  input  logic [l2_fill_width_p-1:0]    m_axi_rdata_i,
  input  logic [1:0]                    m_axi_rresp_i,
  input  logic                          m_axi_rlast_i,
  input  logic                          m_axi_rvalid_i,
  output logic                          m_axi_rready_o,
  output logic                          error_o
);

  localparam int NumBeats = l2_block_width_p / l2_fill_width_p;
  localparam int CntW     = $clog2(NumBeats) + 1;
  localparam int BlkOffW  = $clog2(l2_block_width_p / 8);
  localparam int WideW    = (caddr_width_p > axi_addr_width_p) ? caddr_width_p : axi_addr_width_p;
  localparam logic [CntW-1:0]          LastBeat = CntW'(NumBeats - 1);
  localparam logic [caddr_width_p-1:0] OffMask  = caddr_width_p'((1 << BlkOffW) - 1);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_e;

  state_e                        state_q, state_d;
  logic [axi_addr_width_p-1:0]   addr_q, addr_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic                          error_q, error_d;
  logic [caddr_width_p-1:0]      blk_addr;
  logic [WideW-1:0]              blk_addr_wide;
  logic                          rd_hs, wr_hs;

  // Block-align the packet address, then resize to the AXI address width before rebasing.
  assign blk_addr      = dma_pkt_i[caddr_width_p-1:0] & ~OffMask;
  assign blk_addr_wide = WideW'(blk_addr);

  assign rd_hs = (state_q == RD_DATA) && m_axi_rvalid_i && dma_data_ready_and_i;
  assign wr_hs = (state_q == WR_DATA) && dma_data_v_i && m_axi_wready_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    case (state_q)
      IDLE: if (dma_pkt_v_i) begin
        addr_d  = axi_addr_width_p'(blk_addr_wide) + axi_base_addr_p;
        cnt_d   = '0;
        state_d = dma_pkt_i[caddr_width_p] ? WR_ADDR : RD_ADDR;
      end
      RD_ADDR: if (m_axi_arready_i) state_d = RD_DATA;
      RD_DATA: if (rd_hs) begin
        cnt_d = cnt_q + CntW'(1);
        if (m_axi_rresp_i != 2'b00) error_d = 1'b1;
        if (m_axi_rlast_i) state_d = IDLE;
      end
      WR_ADDR: if (m_axi_awready_i) state_d = WR_DATA;
      WR_DATA: if (wr_hs) begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastBeat) state_d = WR_RESP;
      end
      WR_RESP: if (m_axi_bvalid_i) begin
        if (m_axi_bresp_i != 2'b00) error_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  // Handshake outputs are forced low while reset is held, even before the state register clears.
  assign dma_pkt_yumi_o  = reset_n_i && (state_q == IDLE) && dma_pkt_v_i;
  assign m_axi_arvalid_o = reset_n_i && (state_q == RD_ADDR);
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arlen_o   = 8'(NumBeats - 1);
  assign m_axi_arsize_o  = 3'($clog2(l2_fill_width_p / 8));
  assign m_axi_arburst_o = 2'b01;
  assign m_axi_rready_o  = reset_n_i && (state_q == RD_DATA) && dma_data_ready_and_i;
  assign dma_data_v_o    = reset_n_i && (state_q == RD_DATA) && m_axi_rvalid_i;
  assign dma_data_o      = m_axi_rdata_i;

  assign m_axi_awvalid_o = reset_n_i && (state_q == WR_ADDR);
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awlen_o   = 8'(NumBeats - 1);
  assign m_axi_awsize_o  = 3'($clog2(l2_fill_width_p / 8));
  assign m_axi_awburst_o = 2'b01;
  assign m_axi_wvalid_o  = reset_n_i && (state_q == WR_DATA) && dma_data_v_i;
  assign m_axi_wdata_o   = dma_data_i;
  assign m_axi_wstrb_o   = '1;
  assign m_axi_wlast_o   = (state_q == WR_DATA) && (cnt_q == LastBeat);
  assign dma_data_yumi_o = m_axi_wvalid_o && m_axi_wready_i;
  assign m_axi_bready_o  = reset_n_i && (state_q == WR_RESP);
  assign error_o         = error_q;

  // The slave's rlast ends the burst; the beat counter only cross-checks it.
  rlastOnFinalBeat: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (rd_hs && m_axi_rlast_i) |-> (cnt_q == LastBeat));

endmodule

// File: doc/bp_dma_to_axi_master.md
Name: bp_dma_to_axi_master

Overview:
- Bridges the L2 cache DMA interface of the unicore simulation top to an AXI4 (full) master port facing DRAM, or the Zynq HP port in hardware.
- Consumes `dma_pkt`, `dma_data` (write) and produces `dma_data` (read) toward the L2.
- Converts each DMA packet into exactly one fixed-length INCR burst.
- Handles one transaction at a time; no reordering.

Parameters:
- `caddr_width_p`, 32, DMA packet address width.
- `l2_fill_width_p`, 64, DMA data beat width; equals AXI data width.
- `l2_block_width_p`, 512, cache block size in bits; burst beats = `l2_block_width_p/l2_fill_width_p` (N, power of 2, ≤256).
- `axi_addr_width_p`, 32, AXI address width.
- `axi_base_addr_p`, 32'h0, added to every DMA address before issue.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, synchronous, active-low.
- `dma_pkt_i` in `caddr_width_p+1`: {`write_not_read`, `addr`}.
- `dma_pkt_v_i` in 1 / `dma_pkt_yumi_o` out 1: packet valid / consume.
- `dma_data_i` in `l2_fill_width_p`; `dma_data_v_i` in 1; `dma_data_yumi_o` out 1: write beats from L2.
- `dma_data_o` out `l2_fill_width_p`; `dma_data_v_o` out 1; `dma_data_ready_and_i` in 1: read beats to L2.
- `m_axi_awaddr_o`, `m_axi_araddr_o` out `axi_addr_width_p`: burst addresses.
- `m_axi_awvalid_o`, `m_axi_arvalid_o` out 1; `m_axi_awready_i`, `m_axi_arready_i` in 1.
- `m_axi_awlen_o`, `m_axi_arlen_o` out 8: constant N-1.
- `m_axi_awsize_o`, `m_axi_arsize_o` out 3: constant `log2(l2_fill_width_p/8)`.
- `m_axi_awburst_o`, `m_axi_arburst_o` out 2: constant 2'b01 (INCR).
- `m_axi_wdata_o` out `l2_fill_width_p`; `m_axi_wstrb_o` out `l2_fill_width_p/8` (all ones); `m_axi_wlast_o` out 1; `m_axi_wvalid_o` out 1; `m_axi_wready_i` in 1.
- `m_axi_bresp_i` in 2; `m_axi_bvalid_i` in 1; `m_axi_bready_o` out 1.
- `m_axi_rdata_i` in `l2_fill_width_p`; `m_axi_rresp_i` in 2; `m_axi_rlast_i` in 1; `m_axi_rvalid_i` in 1; `m_axi_rready_o` out 1.
- `error_o` out 1: sticky; set on any non-OKAY `bresp` or `rresp`.

Behaviour:
- **Reset** (`reset_n_i`=0 at a clock edge):
  - State becomes IDLE; beat counter becomes 0; `error_o` becomes 0.
  - All valid/ready/yumi outputs are 0 during reset.
  - Reset mid-burst abandons the burst with no drain; the system resets the AXI slave simultaneously.
- **FSM states:** IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- **IDLE:**
  - `dma_pkt_yumi_o` = `dma_pkt_v_i` (combinational); all other outputs are inactive.
  - On yumi, latch `addr_r` = `axi_base_addr_p` + (`addr` with low `log2(l2_block_width_p/8)` bits cleared), truncated or zero-extended to `axi_addr_width_p`.
  - Clear the beat counter.
  - Next state is WR_ADDR if `write_not_read`, else RD_ADDR.
- **RD_ADDR:**
  - `arvalid`=1 and `araddr`=`addr_r`, held stable until `arready`.
  - On handshake go to RD_DATA. `arvalid` rises 1 cycle after yumi.
- **RD_DATA:**
  - Pass-through: `dma_data_o`=`rdata`, `dma_data_v_o`=`rvalid`, `rready`=`dma_data_ready_and_i`.
  - On handshake with `rlast`=1 go to IDLE.
  - `rlast` is trusted; the counter is used only for an assertion that `rlast` arrives at beat N-1.
  - On a non-OKAY `rresp`, set `error_o`; data is still forwarded.
- **WR_ADDR:**
  - `awvalid`=1 until `awready`, then go to WR_DATA.
  - The W channel is not issued before the AW handshake.
- **WR_DATA:**
  - `wvalid`=`dma_data_v_i`, `wdata`=`dma_data_i`, `dma_data_yumi_o`=`dma_data_v_i & wready`.
  - `wlast`=(count==N-1).
  - On each handshake, count increments; on the last beat go to WR_RESP.
  - No `wvalid` is driven without `dma_data_v_i`.
- **WR_RESP:** `bready`=1; on `bvalid` go to IDLE; a non-OKAY `bresp` sets `error_o`.
- **New packets:** accepted only in IDLE, so the minimum gap is 1 IDLE cycle between transactions.
- **Simultaneous events:**
  - `arready` and `rvalid` in the same cycle as the address handshake: `rvalid` is ignored until RD_DATA; this is legal because the slave holds it.
  - `dma_pkt_v_i` arriving while busy is held off by the L2 (yumi=0).
- **Counter:** width `log2(N)+1`, never wraps within a burst.

Test Plan:
- **Read:** pkt {0, 32'h8000_0040}, N=8, base 0 → `araddr`=32'h8000_0040, `arlen`=7, `arsize`=3, `arburst`=1. 8 R beats 0..7 (last with `rlast`) appear on `dma_data_o` in order; return to IDLE; `error_o`=0.
- **Write:** pkt {1, 32'h8000_0047} → `awaddr`=32'h8000_0040. 8 `dma_data` beats forwarded with `wstrb`=8'hFF and `wlast` only on the 8th. `bready` is high until `bvalid`; then IDLE.
- **Backpressure:** random `wready`/`arready`/`rvalid` stalls and `dma_data_ready_and_i` toggling each cycle → no lost or duplicated beats; `awvalid`/`arvalid` and addresses stay stable until handshake.
- **Errors:** `bresp`=2'b10 on a write, then an OKAY read → `error_o` rises the cycle after `bvalid` and stays 1 until reset.
- **Reset:** `reset_n_i` low during beat 3 of a write → next cycle all valids are 0 and state is IDLE. A following read completes normally.
- **Back-to-back:** read followed by write packets → `arvalid` precedes `awvalid` and the transactions do not overlap.
